// File: rtl/apb_slave_mem.sv
// APB slave with a word-addressed register file: programmable wait states,
// byte-lane writes, a read-only low region, PSLVERR and abort accounting.
module apb_slave_mem #(
   parameter int PADDR_SIZE = 32,
   parameter int PDATA_SIZE = 32,
   parameter int DEPTH      = 16,
   parameter int RO_WORDS   = 2,
   parameter int WAIT_W     = 4
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic [2:0]              PPROT,
   input  logic                    PWRITE,
   input  logic [PDATA_SIZE/8-1:0] PSTRB,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   input  logic [WAIT_W-1:0]       wait_cfg,
   output logic [15:0]             err_count
);

   localparam int NB       = PDATA_SIZE / 8;
   localparam int ADDR_LSB = $clog2(NB);
   localparam int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_ready, w_ready_nxt;
   logic                    r_slverr, w_slverr_nxt;
   logic [15:0]             r_err_count;
   logic [WAIT_W-1:0]       r_cnt;
   logic                    r_write;
   logic                    r_err;
   logic [IW-1:0]           r_idx;
   logic [PDATA_SIZE-1:0]   r_wdata;
   logic [NB-1:0]           r_strb;
   logic [PDATA_SIZE-1:0]   r_mem [DEPTH];

   logic [PADDR_SIZE-1:0]   w_idx_full;
   logic                    w_err;
   logic                    w_capture;
   logic                    w_cnt_dec;
   logic                    w_mem_we;
   logic                    w_err_inc;
   logic                    w_unused;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Protection type is accepted on the bus but plays no part in decode.
   assign w_unused   = ^PPROT;

   assign w_idx_full = PADDR >> ADDR_LSB;
   assign w_err      = (w_idx_full >= PADDR_SIZE'(DEPTH)) |
                       (PWRITE & (w_idx_full < PADDR_SIZE'(RO_WORDS)));

   always_comb begin
      w_state_nxt  = r_state;
      w_ready_nxt  = r_ready;
      w_slverr_nxt = r_slverr;
      w_capture    = 1'b0;
      w_cnt_dec    = 1'b0;
      w_mem_we     = 1'b0;
      w_err_inc    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (PSEL && !PENABLE) begin
               w_capture = 1'b1;
               if (wait_cfg == '0) begin
                  w_ready_nxt  = 1'b1;
                  w_slverr_nxt = w_err;
                  w_state_nxt  = S_RESP;
               end else begin
                  w_state_nxt  = S_WAIT;
               end
            end else if (PSEL && PENABLE) begin
               w_err_inc = 1'b1;
            end
         end
         S_WAIT: begin
            if (!PSEL) begin
               w_err_inc   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (PENABLE) begin
               if (r_cnt == WAIT_W'(1)) begin
                  w_ready_nxt  = 1'b1;
                  w_slverr_nxt = r_err;
                  w_state_nxt  = S_RESP;
               end else begin
                  w_cnt_dec = 1'b1;
               end
            end
         end
         S_RESP: begin
            // Abort and completion both leave the bus idle with outputs cleared.
            if (!PSEL) begin
               w_err_inc    = 1'b1;
               w_ready_nxt  = 1'b0;
               w_slverr_nxt = 1'b0;
               w_state_nxt  = S_IDLE;
            end else if (PENABLE && r_ready) begin
               w_mem_we     = r_write & ~r_err;
               w_err_inc    = r_err;
               w_ready_nxt  = 1'b0;
               w_slverr_nxt = 1'b0;
               w_state_nxt  = S_IDLE;
            end
         end
         default: begin
            w_ready_nxt  = 1'b0;
            w_slverr_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b0;
         r_slverr    <= 1'b0;
         r_err_count <= '0;
         r_cnt       <= '0;
         r_write     <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ready  <= w_ready_nxt;
         r_slverr <= w_slverr_nxt;
         if (w_err_inc) r_err_count <= sat_inc(r_err_count);
         if (w_capture) begin
            r_cnt   <= wait_cfg;
            r_write <= PWRITE;
            r_err   <= w_err;
         end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - WAIT_W'(1);
         end
      end
   end

   // Transfer payload is captured once in the setup phase and never reset.
   always_ff @(posedge PCLK) begin
      if (w_capture) begin
         r_idx   <= w_idx_full[IW-1:0];
         r_wdata <= PWDATA;
         r_strb  <= PSTRB;
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (r_strb[b]) r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
         end
      end
   end

   assign PRDATA    = (r_state == S_RESP && !r_write && !r_err) ? r_mem[r_idx] : '0;
   assign PREADY    = r_ready;
   assign PSLVERR   = r_slverr;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: stimulus pushes expected responses,
// a negedge monitor pops and compares each completed transfer.
module tb_apb_slave_mem;

   localparam int DEPTH = 16;
   localparam int RO    = 2;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic [2:0]  PPROT = 3'd0;
   logic        PWRITE = 1'b0;
   logic [3:0]  PSTRB = 4'h0;
   logic [31:0] PADDR = 32'h0;
   logic [31:0] PWDATA = 32'h0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [3:0]  wait_cfg = 4'h0;
   logic [15:0] err_count;

   apb_slave_mem #(
      .PADDR_SIZE(32), .PDATA_SIZE(32), .DEPTH(DEPTH), .RO_WORDS(RO), .WAIT_W(4)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT),
      .PWRITE(PWRITE), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .wait_cfg(wait_cfg), .err_count(err_count)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_mem [DEPTH];
   int          m_errs = 0;

   function automatic logic [15:0] m_errcnt();
      return (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge PCLK) begin : monitor
      exp_t e;
      if (!PRESET && PSEL && PENABLE && PREADY) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got PREADY=1 expected no transfer");
         end else begin
            e = exp_q.pop_front();
            check32("prdata", PRDATA, e.rdata);
            check32("pslverr", {31'b0, PSLVERR}, {31'b0, e.slverr});
         end
      end
   end

   // Reference: word array, byte merge, error rule and error tally from plain arithmetic.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [3:0] wcfg, output int waits);
      int   idx;
      logic err;
      exp_t e;
      idx      = int'(addr >> 2);
      err      = (idx >= DEPTH) || (wr && idx < RO);
      e.slverr = err;
      e.rdata  = (!wr && !err) ? m_mem[idx] : 32'h0;
      if (err) m_errs++;
      else if (wr) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
      exp_q.push_back(e);
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr;
      PWDATA = wd; PSTRB = strb; wait_cfg = wcfg; PPROT = 3'($urandom);
      @(posedge PCLK); #1;
      PENABLE = 1'b1; PWDATA = ~wd; PSTRB = ~strb; wait_cfg = 4'($urandom);
      waits = 0;
      while (1) begin
         @(negedge PCLK);
         if (PREADY) break;
         waits++;
         if (waits > 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no PREADY after %0d cycles expected %0d", waits, wcfg);
            break;
         end
         @(posedge PCLK); #1;
      end
      @(posedge PCLK); #1;
   endtask

   task automatic idle(input int n);
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   initial begin
      int          w;
      int          k;
      logic [31:0] addr, wd;
      logic        wr;
      logic [3:0]  strb, wc;

      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      #12;
      check32("rst_pready", {31'b0, PREADY}, 32'h0);
      check32("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
      check32("rst_prdata", PRDATA, 32'h0);
      check32("rst_errcnt", {16'h0, err_count}, 32'h0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      idle(2);

      // Dirty the state, then reset in the middle of a waited write.
      xfer(32'h14, 1'b1, 32'h5555AAAA, 4'hF, 4'd0, w);
      xfer(32'h40, 1'b0, 32'h0, 4'h0, 4'd0, w);
      idle(1);
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h14; PWRITE = 1'b1;
      PWDATA = 32'h12345678; PSTRB = 4'hF; wait_cfg = 4'd3;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #2;
      PRESET = 1'b1;
      #1;
      check32("midrst_pready", {31'b0, PREADY}, 32'h0);
      check32("midrst_pslverr", {31'b0, PSLVERR}, 32'h0);
      check32("midrst_prdata", PRDATA, 32'h0);
      check32("midrst_errcnt", {16'h0, err_count}, 32'h0);
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_errs = 0;
      idle(1);
      xfer(32'h14, 1'b0, 32'h0, 4'h0, 4'd0, w);

      // Zero-wait write then read.
      xfer(32'h14, 1'b1, 32'hDEADBEEF, 4'hF, 4'd0, w);
      check32("zw_wr_waits", w, 32'd0);
      xfer(32'h14, 1'b0, 32'h0, 4'h0, 4'd0, w);
      check32("zw_rd_waits", w, 32'd0);

      // Byte lanes with wait states.
      xfer(32'h0C, 1'b1, 32'h11223344, 4'hF, 4'd0, w);
      xfer(32'h0C, 1'b1, 32'hAABBCCDD, 4'b0101, 4'd3, w);
      check32("lane_waits", w, 32'd3);
      xfer(32'h0C, 1'b0, 32'h0, 4'h0, 4'd2, w);
      check32("lane_rd_waits", w, 32'd2);

      // Error responses.
      xfer(32'h40, 1'b0, 32'h0, 4'h0, 4'd0, w);
      check32("err_oob_cnt", {16'h0, err_count}, 32'd1);
      xfer(32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 4'd0, w);
      check32("err_ro_cnt", {16'h0, err_count}, 32'd2);
      xfer(32'h04, 1'b0, 32'h0, 4'h0, 4'd0, w);

      // Zero strobes complete OKAY without writing; low address bits are ignored.
      xfer(32'h20, 1'b1, 32'hFFFFFFFF, 4'h0, 4'd1, w);
      xfer(32'h23, 1'b0, 32'h0, 4'h0, 4'd0, w);
      xfer(32'h17, 1'b0, 32'h0, 4'h0, 4'd1, w);

      // Abort after two access cycles of a waited write.
      xfer(32'h1C, 1'b1, 32'hCAFEF00D, 4'hF, 4'd0, w);
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h1C; PWRITE = 1'b1;
      PWDATA = 32'h0BADBEEF; PSTRB = 4'hF; wait_cfg = 4'd5;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      repeat (2) @(posedge PCLK);
      #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      m_errs++;
      check32("abort_pready", {31'b0, PREADY}, 32'h0);
      check32("abort_errcnt", {16'h0, err_count}, {16'h0, m_errcnt()});
      xfer(32'h1C, 1'b0, 32'h0, 4'h0, 4'd0, w);
      check32("abort_next_waits", w, 32'd0);

      // Randomised traffic across legal, read-only and out-of-range words.
      repeat (300) begin
         addr = 32'($urandom_range(0, (DEPTH + 4) * 4 - 1));
         wr   = 1'($urandom_range(0, 1));
         wd   = $urandom;
         strb = 4'($urandom);
         wc   = 4'($urandom_range(0, 3));
         xfer(addr, wr, wd, strb, wc, w);
         check32("rand_waits", w, {28'h0, wc});
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      check32("rand_errcnt", {16'h0, err_count}, {16'h0, m_errcnt()});

      // Approach saturation with IDLE protocol violations, then cross it back-to-back.
      k = 65535 - m_errs - 300;
      PSEL = 1'b1; PENABLE = 1'b1;
      repeat (k) @(posedge PCLK);
      #1;
      m_errs += k;
      PENABLE = 1'b0;
      check32("viol_errcnt", {16'h0, err_count}, {16'h0, m_errcnt()});
      repeat (300) xfer(32'h40 + 32'(4 * $urandom_range(0, 15)), 1'b0, 32'h0, 4'h0, 4'd0, w);
      check32("sat_reach", {16'h0, err_count}, 32'h0000FFFF);
      repeat (300) xfer(32'h40 + 32'(4 * $urandom_range(0, 15)), 1'b0, 32'h0, 4'h0, 4'd0, w);
      check32("sat_hold", {16'h0, err_count}, {16'h0, m_errcnt()});
      idle(2);
      check32("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
